// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: parameterised SPI slave (any mode, either bit order, 2..64-bit words) in the clk domain.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err_o pulse on aborted frames.
module spi_slave_cfg #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_load_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                  frame_err_o
`endif
);
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic POL = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, XFER, WAIT} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d, rx_data_q, rx_data_d, rx_word;
    logic [DATA_WIDTH-2:0]  rx_sr_q, rx_sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   miso_q, miso_d, tx_load_q, tx_load_d, rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                   ferr_q, ferr_d;
`endif
    logic cs_s, sck_s, mosi_s, cs_fall, cs_rise, lead, trail, sample, shift;

    function automatic logic head(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] adv(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall = cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;
    assign lead    = (sck_prev_q == POL) & (sck_s != POL);
    assign trail   = (sck_prev_q != POL) & (sck_s == POL);
    assign sample  = (CPHA != 0) ? trail : lead;
    assign shift   = (CPHA != 0) ? lead : trail;
    // The rx register keeps only the previous DATA_WIDTH-1 bits; the current mosi completes the word.
    assign rx_word = (MSB_FIRST != 0) ? {rx_sr_q, mosi_s} : {mosi_s, rx_sr_q};

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        tx_load_d  = 1'b0;
        rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ferr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: if (cs_fall) begin
                tx_load_d = 1'b1;
                cnt_d     = '0;
                state_d   = XFER;
                tx_sr_d   = (CPHA != 0) ? tx_data_i : adv(tx_data_i);
                miso_d    = (CPHA != 0) ? miso_q : head(tx_data_i);
            end
            XFER: begin
                if (shift) begin
                    miso_d  = head(tx_sr_q);
                    tx_sr_d = adv(tx_sr_q);
                end
                if (sample) begin
                    rx_sr_d = (MSB_FIRST != 0) ? rx_word[DATA_WIDTH-2:0] : rx_word[DATA_WIDTH-1:1];
                    cnt_d   = cnt_q + CW'(1);
                end
                if (sample && cnt_q == LAST) begin
                    rx_data_d  = rx_word;
                    rx_valid_d = 1'b1;
                    state_d    = cs_rise ? IDLE : WAIT;
                end else if (cs_rise) begin
                    state_d = IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    ferr_d  = (cnt_d != '0);
`endif
                end
            end
            WAIT: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= {SYNC_STAGES{POL}};
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= POL;
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            tx_load_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            ferr_q      <= 1'b0;
`endif
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            tx_load_q   <= tx_load_d;
            rx_valid_q  <= rx_valid_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            ferr_q      <= ferr_d;
`endif
        end
    end

    assign miso_o     = miso_q;
    assign tx_load_o  = tx_load_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q == XFER);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err_o = ferr_q;
`endif
endmodule

// File: tb/tb_spi_slave_cfg.sv
// tb_spi_slave_cfg: three slave configurations driven by a behavioural SPI master with a word-level model.
`timescale 1ns/1ps
module tb_spi_slave_cfg;
    localparam int H = 8;

    logic        clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic [2:0]  cs = 3'b111, miso, txl, rxv, busy, ferr;
    logic [31:0] tx0 = '0, rx0;
    logic [15:0] tx1 = '0, rx1;
    logic [7:0]  tx2 = '0, rx2;
    int          total = 0, bad = 0;
    logic [63:0] exp_rx [3], pend_val [3];
    bit          pend [3];
    int          nrx [3], ntx [3], nferr [3];

    always #5 clk = ~clk;

    spi_slave_cfg u0 (
        .clk(clk), .rst_n(rst_n), .cs_n_i(cs[0]), .sck_i(sck), .mosi_i(mosi), .miso_o(miso[0]),
        .tx_data_i(tx0), .tx_load_o(txl[0]), .rx_data_o(rx0), .rx_valid_o(rxv[0]), .busy_o(busy[0])
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err_o(ferr[0])
`endif
    );
    spi_slave_cfg #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cs_n_i(cs[1]), .sck_i(sck), .mosi_i(mosi), .miso_o(miso[1]),
        .tx_data_i(tx1), .tx_load_o(txl[1]), .rx_data_o(rx1), .rx_valid_o(rxv[1]), .busy_o(busy[1])
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err_o(ferr[1])
`endif
    );
    spi_slave_cfg #(.DATA_WIDTH(8), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst_n(rst_n), .cs_n_i(cs[2]), .sck_i(sck), .mosi_i(mosi), .miso_o(miso[2]),
        .tx_data_i(tx2), .tx_load_o(txl[2]), .rx_data_o(rx2), .rx_valid_o(rxv[2]), .busy_o(busy[2])
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err_o(ferr[2])
`endif
    );
`ifndef SPI_SLAVE_FRAME_ERR_EN
    assign ferr = '0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] rxd(input int k);
        return (k == 0) ? 64'(rx0) : (k == 1) ? 64'(rx1) : 64'(rx2);
    endfunction

    function automatic logic [63:0] mask(input int w);
        return (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

    // Bit sent at position i of a frame; positions past the word are filler.
    function automatic logic bitof(input logic [63:0] mo, input int w, input bit msb, input int i);
        if (i >= w) return i[0];
        return msb ? mo[w-1-i] : mo[i];
    endfunction

    // Word-level model: rx_data holds the last completed word; rx_valid only when a word is due.
    always @(negedge clk) if (rst_n) for (int k = 0; k < 3; k++) begin
        if (rxv[k]) begin
            nrx[k]++;
            chk($sformatf("rx_valid%0d due", k), 64'(pend[k]), 64'd1);
            exp_rx[k] = pend_val[k];
            pend[k] = 1'b0;
        end
        chk($sformatf("rx_data%0d", k), rxd(k), exp_rx[k]);
        if (txl[k]) ntx[k]++;
        if (ferr[k]) nferr[k]++;
    end

    task automatic rst_chk();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset miso%0d", k), 64'(miso[k]), 64'd0);
            chk($sformatf("reset tx_load%0d", k), 64'(txl[k]), 64'd0);
            chk($sformatf("reset rx_valid%0d", k), 64'(rxv[k]), 64'd0);
            chk($sformatf("reset busy%0d", k), 64'(busy[k]), 64'd0);
            chk($sformatf("reset rx_data%0d", k), rxd(k), 64'd0);
            chk($sformatf("reset frame_err%0d", k), 64'(ferr[k]), 64'd0);
        end
    endtask

    task automatic frame(input int k, input bit cpol, input bit cpha, input bit msb, input int w, input int ncyc,
                         input logic [63:0] mo, input bit keep, output logic [63:0] mi, output logic [63:0] seq);
        mi = '0;
        seq = '0;
        sck = cpol;
        mosi = bitof(mo, w, msb, 0);
        wait_clk(H);
        cs[k] = 1'b0;
        wait_clk(H);
        chk($sformatf("busy%0d after cs fall", k), 64'(busy[k]), 64'd1);
        for (int i = 0; i < ncyc; i++) begin
            if (cpha) begin
                sck = ~cpol;
                mosi = bitof(mo, w, msb, i);
                wait_clk(H);
            end
            seq[i] = miso[k];
            if (i < w) mi[msb ? w-1-i : i] = miso[k];
            if (i == w - 1) begin
                pend_val[k] = mo & mask(w);
                pend[k] = 1'b1;
            end
            sck = cpha ? cpol : ~cpol;
            wait_clk(H);
            if (!cpha) begin
                sck = cpol;
                mosi = bitof(mo, w, msb, i + 1);
                wait_clk(H);
            end
        end
        chk($sformatf("rx_valid%0d timeout", k), 64'(pend[k]), 64'd0);
        chk($sformatf("busy%0d before cs rise", k), 64'(busy[k]), 64'(ncyc < w));
        if (!keep) begin
            cs[k] = 1'b1;
            wait_clk(H);
            chk($sformatf("busy%0d after cs rise", k), 64'(busy[k]), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] mi, seq;
        int r0, t0, f0;
        for (int k = 0; k < 3; k++) begin
            exp_rx[k] = '0;
            pend_val[k] = '0;
            pend[k] = 1'b0;
            nrx[k] = 0;
            ntx[k] = 0;
            nferr[k] = 0;
        end
        wait_clk(3);
        rst_chk();
        rst_n = 1'b1;
        wait_clk(H);

        tx0 = 32'hA5A50F0F; t0 = ntx[0]; r0 = nrx[0];
        frame(0, 0, 0, 1, 32, 32, 64'h12345678, 0, mi, seq);
        chk("mode0 master word", mi, 64'hA5A50F0F);
        chk("mode0 rx_data", 64'(rx0), 64'h12345678);
        chk("mode0 tx_load count", 64'(ntx[0] - t0), 64'd1);
        chk("mode0 rx_valid count", 64'(nrx[0] - r0), 64'd1);

        tx0 = 32'h0BADF00D; r0 = nrx[0]; f0 = nferr[0];
        frame(0, 0, 0, 1, 32, 10, 64'hFFFFFFFF, 0, mi, seq);
        chk("abort rx_valid count", 64'(nrx[0] - r0), 64'd0);
        chk("abort rx_data kept", 64'(rx0), 64'h12345678);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        chk("abort frame_err count", 64'(nferr[0] - f0), 64'd1);
`endif

        t0 = ntx[0]; r0 = nrx[0]; f0 = nferr[0];
        frame(0, 0, 0, 1, 32, 0, 64'h0, 0, mi, seq);
        chk("empty cs tx_load count", 64'(ntx[0] - t0), 64'd1);
        chk("empty cs rx_valid count", 64'(nrx[0] - r0), 64'd0);
        chk("empty cs frame_err count", 64'(nferr[0] - f0), 64'd0);

        tx0 = 32'h0F0F1235; r0 = nrx[0];
        frame(0, 0, 0, 1, 32, 40, 64'hCAFEF00D, 0, mi, seq);
        chk("overclock rx_valid count", 64'(nrx[0] - r0), 64'd1);
        chk("overclock rx_data", 64'(rx0), 64'hCAFEF00D);
        chk("overclock master word", mi, 64'h0F0F1235);
        chk("overclock miso static", 64'(seq[39:31]), 64'h1FF);

        tx1 = 16'h1357; t0 = ntx[1]; r0 = nrx[1];
        frame(1, 1, 1, 1, 16, 16, 64'hBEEF, 0, mi, seq);
        chk("mode3 master word", mi, 64'h1357);
        chk("mode3 rx_data", 64'(rx1), 64'hBEEF);
        chk("mode3 rx_valid count", 64'(nrx[1] - r0), 64'd1);
        chk("mode3 tx_load count", 64'(ntx[1] - t0), 64'd1);

        tx2 = 8'h80; r0 = nrx[2];
        frame(2, 0, 0, 0, 8, 8, 64'h01, 0, mi, seq);
        chk("lsb rx_data", 64'(rx2), 64'h01);
        chk("lsb master word", mi, 64'h80);
        chk("lsb miso sequence", 64'(seq[7:0]), 64'h80);
        chk("lsb rx_valid count", 64'(nrx[2] - r0), 64'd1);

        tx0 = 32'h55AA33CC;
        frame(0, 0, 0, 1, 32, 5, 64'hFFFFFFFF, 1, mi, seq);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_rx[k] = '0;
            pend[k] = 1'b0;
        end
        wait_clk(2);
        rst_chk();
        cs[0] = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(H);
        r0 = nrx[0];
        frame(0, 0, 0, 1, 32, 32, 64'h89ABCDEF, 0, mi, seq);
        chk("post-reset rx_data", 64'(rx0), 64'h89ABCDEF);
        chk("post-reset master word", mi, 64'h55AA33CC);
        chk("post-reset rx_valid count", 64'(nrx[0] - r0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_cfg.md
Name: spi_slave_cfg

Overview:
Parameterised SPI slave and the successor to the fixed 32-bit, mode-0-only SPI slave. Supports configurable word width, all four SPI modes and either bit order. Adds a receive-valid strobe, a transmit-load strobe and abort detection. Sits between an external SPI master and FPGA fabric logic, fully in the clk domain. SPI inputs are synchronised internally.

Parameters:
DATA_WIDTH, 32, bits per frame; legal range 2..64
CPOL, 0, SCK idle level
CPHA, 0, 0: sample on leading edge, drive on trailing; 1: drive on leading, sample on trailing
MSB_FIRST, 1, 1: bit DATA_WIDTH-1 first on both lines; 0: bit 0 first
SYNC_STAGES, 2, synchroniser flops on cs_n/sck/mosi; legal range 2..3

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  SPI chip select, active low, asynchronous to clk
sck  in  1  SPI clock, asynchronous to clk
mosi  in  1  SPI data in
miso  out  1  SPI data out, registered
tx_data  in  DATA_WIDTH  word to transmit; captured at frame start
tx_load  out  1  1-cycle pulse: tx_data captured, next word may be presented
rx_data  out  DATA_WIDTH  last complete received word; held until next completion
rx_valid  out  1  1-cycle pulse: rx_data updated
busy  out  1  1 while state==XFER; fabric must not change tx_data while busy

Behaviour:
- Reset: rst_n asynchronous and active low; all logic is in the single clock domain clk. Reset values:
  - state=IDLE; miso=0, tx_load=0, rx_data=0, rx_valid=0, busy=0, bit count=0.
  - Synchroniser flops reset to cs_n=1, sck=CPOL, mosi=0.
- Synchronisation and edge detection:
  - cs_n, sck and mosi pass through SYNC_STAGES flops.
  - Edges are detected from the last synchronised stage and its registered copy.
  - Leading edge: rising if CPOL=0, falling if CPOL=1. Trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- Timing requirement: SCK high and low phases each ≥ SYNC_STAGES+1 clk periods.
- Bit count: width $clog2(DATA_WIDTH+1).
- IDLE:
  - On a synchronised cs_n falling edge: load tx shift register from tx_data, pulse tx_load, clear count, go XFER.
  - CPHA=0: miso is driven with the first bit in that same cycle.
  - CPHA=1: miso holds its value until the first shift edge.
- XFER:
  - Sample edge: shift the synchronised mosi into the rx shift register and increment count.
  - Shift edge: drive the next tx bit onto miso. With CPHA=0, the shift edge that follows the final sample is ignored.
  - When a sample edge brings count to DATA_WIDTH, in the same cycle: rx_data <= assembled word, rx_valid pulses next cycle, state -> WAIT.
  - cs_n rising with count < DATA_WIDTH aborts the frame: go IDLE, rx_data unchanged, no rx_valid.
- WAIT:
  - All SCK edges are ignored; miso holds the last bit driven.
  - cs_n rising -> IDLE.
  - One frame per CS assertion; there is no back-to-back streaming.
- Simultaneous final sample edge and cs_n rising in the same cycle: the word completes (rx_valid asserted) and the state goes directly to IDLE.
- cs_n falling while in WAIT is impossible without a rise first; a glitch shorter than the sync depth may be missed, which is acceptable.
- Bit order: MSB_FIRST=1 shifts left, the tx bit taken from the MSB. MSB_FIRST=0 shifts right, the tx bit taken from the LSB. rx_data is always in natural bit order.
- No clock-edge activity occurs in IDLE; mosi and sck toggling while deselected has no effect.

Optional Feature:
Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit, reset 0). It pulses for 1 cycle when a frame aborts with 1 ≤ count < DATA_WIDTH. A CS assertion with zero sample edges gives no error.
- Undefined: the port and its logic are absent; aborts are silent.

Test Plan:
- Default params, mode 0: tx_data=0xA5A50F0F, master sends 0x12345678 -> rx_data=0x12345678, one rx_valid pulse, master receives 0xA5A50F0F, exactly one tx_load pulse, busy high only between CS fall and the 32nd sample.
- CPOL=1, CPHA=1, DATA_WIDTH=16: master sends 0xBEEF, tx_data=0x1357 -> rx_data=0xBEEF, master reads 0x1357.
- MSB_FIRST=0, DATA_WIDTH=8: mosi bit sequence 1,0,0,0,0,0,0,0 -> rx_data=0x01; tx_data=0x80 -> miso sequence 0,0,0,0,0,0,0,1.
- Abort: 32-bit frame with CS raised after 10 sample edges -> no rx_valid, rx_data keeps its previous 0x12345678, state IDLE. With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses once.
- Over-clocking: 40 SCK cycles in one CS window -> exactly one rx_valid, carrying the first 32 bits; bits 33..40 ignored and miso static after bit 32.
- rst_n low mid-frame after 5 bits, then released and a new full frame sent -> all outputs 0 during reset, new frame received correctly, no stale bits.
